// File: rtl/multi_ball_engine_pkg.sv
// multi_ball_engine_pkg: shared state encodings, palette and sizing helpers
package multi_ball_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Register width for a value range of v entries, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return v > 1 ? $clog2(v) : 1;
  endfunction

  // Channel enables {r,g,b} for a palette slot: white, red, green, blue.
  function automatic logic [2:0] palette(input logic [1:0] idx);
    return idx == 2'd0 ? 3'b111 : idx == 2'd1 ? 3'b100 : idx == 2'd2 ? 3'b010 : 3'b001;
  endfunction

endpackage

// File: rtl/multi_ball_engine_ball_motion.sv
// multi_ball_engine_ball_motion: position and direction of one bouncing ball
module multi_ball_engine_ball_motion
  import multi_ball_engine_pkg::*;
#(
  parameter int INIT_X      = 0,
  parameter int INIT_Y      = 0,
  parameter int INIT_DX     = 0,
  parameter int INIT_DY     = 0,
  parameter int GAME_WIDTH  = 40,
  parameter int GAME_HEIGHT = 30,
  localparam int XW = clog2_min1(GAME_WIDTH),
  localparam int YW = clog2_min1(GAME_HEIGHT)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          iload,
  input  logic          imove,
  output logic [XW-1:0] ox,
  output logic [YW-1:0] oy
);

  localparam logic [XW-1:0] XMAX = XW'(GAME_WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(GAME_HEIGHT - 1);

  logic dx, dy, ndx, ndy;

  // The direction after a bounce check is also the direction of this step.
  assign ndx = dx ? ox != XMAX : ox == '0;
  assign ndy = dy ? oy != YMAX : oy == '0;

  // Reload on reset or IDLE entry, otherwise step one tile per move tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || iload) begin
      ox <= XW'(INIT_X);
      oy <= YW'(INIT_Y);
      dx <= 1'(INIT_DX);
      dy <= 1'(INIT_DY);
    end else if (imove) begin
      ox <= ndx ? ox + XW'(1) : ox - XW'(1);
      oy <= ndy ? oy + YW'(1) : oy - YW'(1);
      dx <= ndx;
      dy <= ndy;
    end
  end

endmodule

// File: rtl/multi_ball_engine.sv
// multi_ball_engine: NUM_BALLS bouncing tile balls with run/pause control and priority colour mux
module multi_ball_engine
  import multi_ball_engine_pkg::*;
#(
  parameter int NUM_BALLS   = 4,
  parameter int GAME_WIDTH  = 40,
  parameter int GAME_HEIGHT = 30,
  parameter int TILE_SHIFT  = 4,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int FRAME_DIV   = 2,
  parameter int VIDEO_WIDTH = 3,
  localparam int IW = clog2_min1(NUM_BALLS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   igame_active,
  input  logic                   ipause,
  input  logic [9:0]             icol,
  input  logic [9:0]             irow,
  output logic                   odraw,
  output logic [IW-1:0]          oidx,
  output logic [VIDEO_WIDTH-1:0] oredv,
  output logic [VIDEO_WIDTH-1:0] ogrnv,
  output logic [VIDEO_WIDTH-1:0] obluv,
  output logic [1:0]             ostate,
  output logic                   oframe_tick
);

  localparam int XW = clog2_min1(GAME_WIDTH);
  localparam int YW = clog2_min1(GAME_HEIGHT);
  localparam int CW = clog2_min1(FRAME_DIV);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 ftick, move, load, visible, any;
  logic [9:0]           tx, ty;
  logic [IW-1:0]        idx;
  logic [2:0]           rgb;
  logic [NUM_BALLS-1:0] hit;
  logic [XW-1:0]        bx [NUM_BALLS];
  logic [YW-1:0]        by [NUM_BALLS];

  assign ftick   = icol == '0 && irow == 10'(ACTIVE_ROWS);
  assign move    = ftick && state == ST_RUN && cnt == CW'(FRAME_DIV - 1);
  assign load    = ftick && state != ST_IDLE && !igame_active;
  assign ostate  = state;
  assign tx      = icol >> TILE_SHIFT;
  assign ty      = irow >> TILE_SHIFT;
  assign visible = icol < 10'(ACTIVE_COLS) && irow < 10'(ACTIVE_ROWS) && state != ST_IDLE;

  // Run/pause/idle control and frame divider, both advancing only at the frame boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (ftick) begin
      if (state == ST_IDLE || !igame_active) begin
        state <= state == ST_IDLE && igame_active ? ST_RUN : ST_IDLE;
        cnt   <= '0;
      end else begin
        state <= ipause ? ST_PAUSE : ST_RUN;
        cnt   <= state != ST_RUN ? cnt : move ? '0 : cnt + CW'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_BALLS; k++) begin : g_ball
    multi_ball_engine_ball_motion #(
      .INIT_X     ((7 * k + 3) % GAME_WIDTH),
      .INIT_Y     ((5 * k + 2) % GAME_HEIGHT),
      .INIT_DX    (k % 2),
      .INIT_DY    ((k / 2) % 2),
      .GAME_WIDTH (GAME_WIDTH),
      .GAME_HEIGHT(GAME_HEIGHT)
    ) u_ball (
      .clock  (clock),
      .reset_n(reset_n),
      .iload  (load),
      .imove  (move),
      .ox     (bx[k]),
      .oy     (by[k])
    );
    assign hit[k] = visible && tx == 10'(bx[k]) && ty == 10'(by[k]);
  end

  // Lowest-numbered ball covering the pixel wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = NUM_BALLS - 1; k >= 0; k--) begin
      if (hit[k]) begin
        any = 1'b1;
        idx = IW'(k);
      end
    end
  end

  assign rgb = any ? palette(2'(idx)) : 3'b000;

  // Pixel outputs registered one clock behind icol/irow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      odraw       <= 1'b0;
      oidx        <= '0;
      oredv       <= '0;
      ogrnv       <= '0;
      obluv       <= '0;
      oframe_tick <= 1'b0;
    end else begin
      odraw       <= any;
      oidx        <= idx;
      oredv       <= {VIDEO_WIDTH{rgb[2]}};
      ogrnv       <= {VIDEO_WIDTH{rgb[1]}};
      obluv       <= {VIDEO_WIDTH{rgb[0]}};
      oframe_tick <= ftick;
    end
  end

endmodule

// File: tb/tb_multi_ball_engine.sv
// tb_multi_ball_engine: model-checked bench for the default engine and a small corner-bounce instance
module tb_multi_ball_engine;

  logic       clock = 1'b0, reset_n = 1'b0, igame_active = 1'b1, ipause = 1'b0;
  logic [9:0] icol = 10'd700, irow = 10'd0;
  logic       odraw, oframe_tick, c_draw, c_idx, c_tick;
  logic [1:0] oidx, ostate, c_state;
  logic [2:0] oredv, ogrnv, obluv, c_r, c_g, c_b;

  int checks = 0, errors = 0;
  int mst, mcnt, mmoves, cmoves;
  int px[4], py[4], pdx[4], pdy[4];
  int cx, cy, cdx, cdy;
  int n, sx, sy;

  always #5 clock = ~clock;

  multi_ball_engine u_dut (
    .clock(clock), .reset_n(reset_n), .igame_active(igame_active), .ipause(ipause),
    .icol(icol), .irow(irow), .odraw(odraw), .oidx(oidx), .oredv(oredv), .ogrnv(ogrnv),
    .obluv(obluv), .ostate(ostate), .oframe_tick(oframe_tick)
  );

  multi_ball_engine #(.NUM_BALLS(1), .GAME_WIDTH(5), .GAME_HEIGHT(4), .FRAME_DIV(1)) u_cor (
    .clock(clock), .reset_n(reset_n), .igame_active(igame_active), .ipause(ipause),
    .icol(icol), .irow(irow), .odraw(c_draw), .oidx(c_idx), .oredv(c_r), .ogrnv(c_g),
    .obluv(c_b), .ostate(c_state), .oframe_tick(c_tick)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int chv(input int d, input int i, input int c);
    return (d != 0 && (i % 4 == 0 || i % 4 == c)) ? 7 : 0;
  endfunction

  task automatic minit();
    for (int k = 0; k < 4; k++) begin
      px[k]  = (7 * k + 3) % 40;
      py[k]  = (5 * k + 2) % 30;
      pdx[k] = k % 2;
      pdy[k] = (k / 2) % 2;
    end
    cx = 3; cy = 2; cdx = 0; cdy = 0;
  endtask

  task automatic step(inout int p, inout int d, input int mx);
    if (d != 0) begin
      if (p == mx) begin d = 0; p = p - 1; end
      else p = p + 1;
    end else begin
      if (p == 0) begin d = 1; p = p + 1; end
      else p = p - 1;
    end
  endtask

  task automatic mupdate(input int ft);
    if (ft == 0) return;
    if (mst == 0) begin
      mst  = igame_active ? 1 : 0;
      mcnt = 0;
    end else if (!igame_active) begin
      mst  = 0;
      mcnt = 0;
      minit();
    end else begin
      if (mst == 1) begin
        step(cx, cdx, 4);
        step(cy, cdy, 3);
        cmoves++;
        if (mcnt == 1) begin
          for (int k = 0; k < 4; k++) begin
            step(px[k], pdx[k], 39);
            step(py[k], pdy[k], 29);
          end
          mmoves++;
        end
        mcnt = (mcnt + 1) % 2;
      end
      mst = ipause ? 2 : 1;
    end
  endtask

  // Drive one pixel, predict from the pre-update model, then compare one clock later.
  task automatic cyc(input int col, input int row);
    int vis, ed, ei, ch, ft;
    icol = 10'(col);
    irow = 10'(row);
    vis = (col < 640 && row < 480 && mst != 0) ? 1 : 0;
    ed = 0;
    ei = 0;
    for (int k = 3; k >= 0; k--)
      if (vis != 0 && col / 16 == px[k] && row / 16 == py[k]) begin ed = 1; ei = k; end
    ch = (vis != 0 && col / 16 == cx && row / 16 == cy) ? 1 : 0;
    ft = (col == 0 && row == 480) ? 1 : 0;
    mupdate(ft);
    @(posedge clock);
    #1;
    chk("draw", odraw, ed);
    chk("idx", oidx, ei);
    chk("red", oredv, chv(ed, ei, 1));
    chk("grn", ogrnv, chv(ed, ei, 2));
    chk("blu", obluv, chv(ed, ei, 3));
    chk("tick", oframe_tick, ft);
    chk("state", ostate, mst);
    chk("c_draw", c_draw, ch);
    chk("c_idx", c_idx, 0);
    chk("c_red", c_r, chv(ch, 0, 1));
    chk("c_blu", c_b, chv(ch, 0, 3));
    chk("c_tick", c_tick, ft);
    chk("c_state", c_state, mst);
  endtask

  task automatic frame();
    for (int k = 0; k < 4; k++) cyc(px[k] * 16 + 8, py[k] * 16 + 8);
    cyc(px[0] * 16 + 15, py[0] * 16 + 15);
    cyc(px[0] * 16 + 16, py[0] * 16);
    cyc(cx * 16 + 3, cy * 16 + 12);
    cyc(700, py[0] * 16 + 4);
    cyc(0, 0);
    cyc(639, 479);
    cyc(0, 480);
    cyc(5, 500);
  endtask

  initial begin
    mst = 0; mcnt = 0; mmoves = 0; cmoves = 0;
    minit();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_draw", odraw, 0);
    chk("rst_state", ostate, 0);
    chk("rst_red", oredv, 0);
    chk("rst_tick", oframe_tick, 0);
    chk("rst_c_draw", c_draw, 0);
    reset_n = 1'b1;
    chk("init_b0x", px[0], 3);
    chk("init_b0y", py[0], 2);
    frame();
    chk("first_tick_run", ostate, 1);
    cyc(48, 32);
    chk("lit_init_draw", odraw, 1);
    chk("lit_init_white", ogrnv, 7);
    n = 0;
    while (mmoves < 2 && n < 50) begin frame(); n++; end
    chk("lit_x_after2", px[0], 1);
    chk("lit_y_after2", py[0], 0);
    cyc(21, 5);
    chk("lit_draw_after2", odraw, 1);
    while (mmoves < 4 && n < 100) begin frame(); n++; end
    chk("lit_x_after4", px[0], 1);
    chk("lit_dx_after4", pdx[0], 1);
    cyc(21, 37);
    chk("lit_draw_after4", odraw, 1);
    while (cmoves < 23 && n < 200) begin frame(); n++; end
    chk("lit_corner_x", cx, 4);
    chk("lit_corner_y", cy, 3);
    chk("lit_corner_dxdy", cdx * 2 + cdy, 3);
    cyc(67, 51);
    chk("lit_corner_draw", c_draw, 1);
    frame();
    chk("lit_reflect_xy", cx * 10 + cy, 32);
    chk("lit_reflect_dxdy", cdx * 2 + cdy, 0);
    cyc(51, 35);
    chk("lit_reflect_draw", c_draw, 1);
    ipause = 1'b1;
    frame();
    chk("lit_paused", ostate, 2);
    sx = px[0]; sy = py[0];
    repeat (10) frame();
    cyc(sx * 16 + 8, sy * 16 + 8);
    chk("lit_frozen_draw", odraw, 1);
    chk("lit_frozen_idx", oidx, 0);
    ipause = 1'b0;
    frame();
    chk("lit_resumed", ostate, 1);
    while (mmoves < 256 && n < 2000) begin frame(); n++; end
    chk("lit_b1_tile", px[1] * 100 + py[1], 3217);
    chk("lit_b3_tile", px[3] * 100 + py[3], 3217);
    cyc(520, 280);
    chk("lit_overlap_draw", odraw, 1);
    chk("lit_overlap_idx", oidx, 1);
    chk("lit_overlap_red", oredv, 7);
    chk("lit_overlap_grn", ogrnv, 0);
    igame_active = 1'b0;
    cyc(520, 280);
    chk("lit_stop_pending", ostate, 1);
    cyc(0, 480);
    chk("lit_stop_idle", ostate, 0);
    cyc(520, 280);
    chk("lit_idle_black", odraw, 0);
    cyc(48, 32);
    chk("lit_idle_black_b0", odraw, 0);
    igame_active = 1'b1;
    cyc(0, 480);
    chk("lit_restart", ostate, 1);
    cyc(48, 32);
    chk("lit_restart_b0", odraw, 1);
    cyc(700, 32);
    chk("lit_col700", odraw, 0);
    frame();
    cyc(48, 32);
    #2 reset_n = 1'b0;
    #1;
    chk("lit_async_draw", odraw, 0);
    chk("lit_async_state", ostate, 0);
    chk("lit_async_red", oredv, 0);
    chk("lit_async_c_draw", c_draw, 0);
    mst = 0; mcnt = 0;
    minit();
    @(negedge clock);
    reset_n = 1'b1;
    cyc(48, 32);
    chk("lit_postrst_black", odraw, 0);
    cyc(0, 480);
    cyc(48, 32);
    chk("lit_postrst_b0", odraw, 1);
    frame();
    frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
